// File: rtl/nn_inference_ctrl.sv
// Sequencer around the combinational XOR neural_network. It takes a request,
// holds the network inputs for a settle window, captures and thresholds the
// output, and returns the result. It also runs a built-in self-test over all
// four XOR cases.
// Latency: accept at edge k, rsp_valid rises after edge k+SETTLE_CYCLES.
// Self-test: start edge to done pulse is 4*SETTLE_CYCLES+1 cycles.
// Backpressure: rsp_* are held until rsp_ready. req_ready stays low outside
// IDLE, so one request is in flight at a time.
// Ports:
//   clk, rst           - clock and synchronous active-high reset
//   req_*              - request handshake carrying the XOR operands
//   nn_inputs          - registered drive to the network
//   nn_output          - signed network output
//   rsp_*              - result handshake: raw fixed-point value,
//                        thresholded bit, and the operands used
//   selftest_*         - self-test start, busy, done pulse, pass count,
//                        and sticky fail flag
module nn_inference_ctrl #(
  parameter int DATA_WIDTH      = 16,
  parameter int FRACTIONAL_BITS = 12,
  parameter int SETTLE_CYCLES   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [1:0]                   req_inputs,
  output logic [1:0]                   nn_inputs,
  input  logic signed [DATA_WIDTH-1:0] nn_output,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic signed [DATA_WIDTH-1:0] rsp_fixed,
  output logic                         rsp_binary,
  output logic [1:0]                   rsp_inputs,
  input  logic                         selftest_start,
  output logic                         selftest_busy,
  output logic                         selftest_done,
  output logic [2:0]                   selftest_pass_count,
  output logic                         selftest_fail
);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    RESPOND,
    ST_SETTLE,
    ST_DONE
  } state_t;

  localparam logic [3:0] CNT_RELOAD = 4'(SETTLE_CYCLES - 1);
  // 0.5 in the output's fixed-point format
  localparam logic signed [DATA_WIDTH-1:0] THRESH = DATA_WIDTH'(1 << (FRACTIONAL_BITS - 1));

  state_t                       state_q, state_d;
  logic [3:0]                   cnt_q, cnt_d;
  logic [1:0]                   idx_q, idx_d;
  logic [1:0]                   nn_in_q, nn_in_d;
  logic                         rsp_valid_q, rsp_valid_d;
  logic signed [DATA_WIDTH-1:0] rsp_fixed_q, rsp_fixed_d;
  logic                         rsp_bin_q, rsp_bin_d;
  logic [1:0]                   rsp_in_q, rsp_in_d;
  logic [2:0]                   pass_q, pass_d;
  logic                         fail_q, fail_d;
  logic                         cap_bit;

  // Both operands are signed, so every negative output thresholds to 0
  assign cap_bit = (nn_output >= THRESH);

  assign req_ready           = (state_q == IDLE) && !rst && !selftest_start;
  assign nn_inputs           = nn_in_q;
  assign rsp_valid           = rsp_valid_q;
  assign rsp_fixed           = rsp_fixed_q;
  assign rsp_binary          = rsp_bin_q;
  assign rsp_inputs          = rsp_in_q;
  assign selftest_busy       = (state_q == ST_SETTLE);
  assign selftest_done       = (state_q == ST_DONE);
  assign selftest_pass_count = pass_q;
  assign selftest_fail       = fail_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    nn_in_d     = nn_in_q;
    rsp_valid_d = rsp_valid_q;
    rsp_fixed_d = rsp_fixed_q;
    rsp_bin_d   = rsp_bin_q;
    rsp_in_d    = rsp_in_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    case (state_q)
      IDLE: begin
        // A self-test request wins over a simultaneous inference request
        if (selftest_start) begin
          idx_d   = 2'd0;
          nn_in_d = 2'b00;
          pass_d  = 3'd0;
          fail_d  = 1'b0;
          cnt_d   = CNT_RELOAD;
          state_d = ST_SETTLE;
        end else if (req_valid && req_ready) begin
          nn_in_d = req_inputs;
          cnt_d   = CNT_RELOAD;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) begin
          rsp_fixed_d = nn_output;
          rsp_bin_d   = cap_bit;
          rsp_in_d    = nn_in_q;
          rsp_valid_d = 1'b1;
          state_d     = RESPOND;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESPOND: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 4'd0) begin
          if (cap_bit == (nn_in_q[1] ^ nn_in_q[0])) begin
            pass_d = pass_q + 3'd1;
          end else begin
            fail_d = 1'b1;
          end
          if (idx_q != 2'd3) begin
            idx_d   = idx_q + 2'd1;
            nn_in_d = idx_q + 2'd1;
            cnt_d   = CNT_RELOAD;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= 2'd0;
      nn_in_q     <= 2'b00;
      rsp_valid_q <= 1'b0;
      rsp_fixed_q <= '0;
      rsp_bin_q   <= 1'b0;
      rsp_in_q    <= 2'b00;
      pass_q      <= 3'd0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      nn_in_q     <= nn_in_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_fixed_q <= rsp_fixed_d;
      rsp_bin_q   <= rsp_bin_d;
      rsp_in_q    <= rsp_in_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
    end
  end

endmodule

// File: tb/tb_nn_inference_ctrl.sv
// Bench for nn_inference_ctrl: directed scenarios plus a randomized phase,
// all checked every cycle against a timestamp-based transaction model.
module tb_nn_inference_ctrl;
  localparam int S   = 2;
  localparam int THR = 2048;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [1:0]  req_inputs = 2'b00, nn_inputs, rsp_inputs;
  logic [15:0] nn_output, rsp_fixed;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_binary;
  logic        selftest_start = 1'b0, selftest_busy, selftest_done, selftest_fail;
  logic [2:0]  selftest_pass_count;

  // Network stand-in: an ideal XOR table, or a constant stub value
  bit          mode_const = 1'b0;
  logic [15:0] stub_val = 16'h0000;

  function automatic logic [15:0] ideal(input logic [1:0] x);
    case (x)
      2'd0:    return 16'h00A0;
      2'd1:    return 16'h0F00;
      2'd2:    return 16'h0E80;
      default: return 16'hFF40;
    endcase
  endfunction

  function automatic logic [15:0] net_val(input logic [1:0] x);
    return mode_const ? stub_val : ideal(x);
  endfunction

  assign nn_output = mode_const ? stub_val : ideal(nn_inputs);

  nn_inference_ctrl #(.DATA_WIDTH(16), .FRACTIONAL_BITS(12), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_inputs(req_inputs),
    .nn_inputs(nn_inputs), .nn_output(nn_output),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_fixed(rsp_fixed),
    .rsp_binary(rsp_binary), .rsp_inputs(rsp_inputs),
    .selftest_start(selftest_start), .selftest_busy(selftest_busy),
    .selftest_done(selftest_done), .selftest_pass_count(selftest_pass_count),
    .selftest_fail(selftest_fail)
  );

  int total = 0, bad = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction model (timestamps, not cycle states) -------
  int          e = 0;
  bit          started = 0;
  int          req_t0 = -1, st_t0 = -1;
  bit          holding = 0, m_done = 0;
  logic [1:0]  m_nn = 0, m_rsp_in = 0;
  logic [15:0] m_rsp_fixed = 0;
  logic        m_rsp_valid = 0, m_rsp_bin = 0, m_fail = 0;
  int          m_pass = 0;

  always @(posedge clk) begin
    logic [15:0] v;
    int k;
    e++;
    started = 1;
    if (rst) begin
      req_t0 = -1; st_t0 = -1; holding = 0; m_done = 0;
      m_nn = 0; m_rsp_in = 0; m_rsp_fixed = 0; m_rsp_valid = 0; m_rsp_bin = 0;
      m_pass = 0; m_fail = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (holding) begin
      if (rsp_ready) begin holding = 0; m_rsp_valid = 0; end
    end else if (req_t0 >= 0) begin
      if (e - req_t0 == S) begin
        v = net_val(m_nn);
        m_rsp_fixed = v;
        m_rsp_bin   = ($signed(v) >= THR);
        m_rsp_in    = m_nn;
        m_rsp_valid = 1; holding = 1; req_t0 = -1;
      end
    end else if (st_t0 >= 0) begin
      k = e - st_t0;
      if (k % S == 0) begin
        v = net_val(m_nn);
        if (($signed(v) >= THR) == (m_nn[1] ^ m_nn[0])) m_pass++;
        else m_fail = 1;
        if (k / S < 4) m_nn = 2'(k / S);
        else begin st_t0 = -1; m_done = 1; end
      end
    end else begin
      if (selftest_start) begin
        st_t0 = e; m_nn = 0; m_pass = 0; m_fail = 0;
      end else if (req_valid) begin
        req_t0 = e; m_nn = req_inputs;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      cmp("req_ready", req_ready,
          (!holding && req_t0 < 0 && st_t0 < 0 && !m_done && !rst && !selftest_start));
      cmp("nn_inputs", nn_inputs, m_nn);
      cmp("rsp_valid", rsp_valid, m_rsp_valid);
      cmp("rsp_fixed", rsp_fixed, m_rsp_fixed);
      cmp("rsp_binary", rsp_binary, m_rsp_bin);
      cmp("rsp_inputs", rsp_inputs, m_rsp_in);
      cmp("st_busy", selftest_busy, (st_t0 >= 0));
      cmp("st_done", selftest_done, m_done);
      cmp("st_pass", selftest_pass_count, m_pass);
      cmp("st_fail", selftest_fail, m_fail);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issue a request, return edges from accept to rsp_valid (-1 on timeout).
  task automatic send(input logic [1:0] x, output int lat);
    bit ok = 0;
    lat = -1;
    req_valid = 1'b1; req_inputs = x;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    if (!ok) begin cmp("accept_timeout", 0, 1); req_valid = 1'b0; return; end
    @(posedge clk); #1; req_valid = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid) begin lat = n; break; end
    end
    if (lat < 0) cmp("rsp_timeout", 0, 1);
  endtask

  task automatic wait_rsp();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1; break; end
    end
    if (!ok) cmp("rsp_timeout", 0, 1);
  endtask

  // Start a sweep; n = cycles from the start edge to the done pulse.
  task automatic run_selftest(output int n);
    n = -1;
    selftest_start = 1'b1;
    @(posedge clk); #1; selftest_start = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (selftest_done) begin n = i; break; end
    end
    if (n < 0) cmp("done_timeout", 0, 1);
  endtask

  logic [15:0] thr_vals [3] = '{16'd2047, 16'd2048, 16'hF000};
  logic        thr_exp  [3] = '{1'b0, 1'b1, 1'b0};
  logic [15:0] stub_pool[6] = '{16'd2047, 16'd2048, 16'h0000, 16'hF000, 16'h7FFF, 16'h8000};

  initial begin
    int lat, n;
    bit acc;
    // 1. reset with random inputs
    req_valid = 1'($urandom); selftest_start = 1'($urandom);
    req_inputs = 2'($urandom); rsp_ready = 1'($urandom);
    for (int i = 0; i < 3; i++) begin
      tick();
      req_valid = 1'($urandom); selftest_start = 1'($urandom);
      req_inputs = 2'($urandom); rsp_ready = 1'($urandom);
    end
    rst = 1'b0; req_valid = 1'b0; selftest_start = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    cmp("post_rst_ready", req_ready, 1);
    cmp("post_rst_nn", nn_inputs, 0);
    cmp("post_rst_valid", rsp_valid, 0);
    cmp("post_rst_pass", selftest_pass_count, 0);

    // 2. basic request
    tick();
    mode_const = 1'b1; stub_val = 16'h0E00;
    send(2'b01, lat);
    cmp("lat", lat, S);
    cmp("fixed_0E00", rsp_fixed, 16'h0E00);
    cmp("bin_0E00", rsp_binary, 1);
    cmp("inputs_01", rsp_inputs, 2'b01);
    tick();
    cmp("valid_drop", rsp_valid, 0);

    // 3. threshold boundary
    for (int i = 0; i < 3; i++) begin
      tick();
      stub_val = thr_vals[i];
      send(2'(i), lat);
      cmp("thr_bin", rsp_binary, thr_exp[i]);
    end

    // 4. backpressure with a held second request
    tick();
    rsp_ready = 1'b0; stub_val = 16'h0123;
    send(2'b10, lat);
    tick();
    req_valid = 1'b1; req_inputs = 2'b11;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cmp("bp_ready", req_ready, 0);
      cmp("bp_valid", rsp_valid, 1);
      cmp("bp_fixed", rsp_fixed, 16'h0123);
      cmp("bp_inputs", rsp_inputs, 2'b10);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    cmp("bp_ready_last", req_ready, 0);
    @(posedge clk);
    @(negedge clk);
    cmp("bp_accept_next", req_ready, 1);
    @(posedge clk); #1; req_valid = 1'b0;
    wait_rsp();
    cmp("bp_second_in", rsp_inputs, 2'b11);

    // 5. self-test: ideal network, then constant zero
    tick(); tick();
    mode_const = 1'b0;
    run_selftest(n);
    cmp("st_len", n, 4 * S + 1);
    cmp("st_pass4", selftest_pass_count, 4);
    cmp("st_fail0", selftest_fail, 0);
    @(negedge clk);
    cmp("st_done_once", selftest_done, 0);
    tick();
    mode_const = 1'b1; stub_val = 16'h0000;
    run_selftest(n);
    cmp("st_pass2", selftest_pass_count, 2);
    cmp("st_fail1", selftest_fail, 1);

    // 6a. selftest_start and req_valid together
    tick();
    mode_const = 1'b0; rsp_ready = 1'b1;
    req_valid = 1'b1; req_inputs = 2'b01;
    run_selftest(n);
    cmp("col_ready_done", req_ready, 0);
    @(negedge clk);
    cmp("col_ready_after", req_ready, 1);
    @(posedge clk); #1; req_valid = 1'b0;
    wait_rsp();
    cmp("col_rsp_in", rsp_inputs, 2'b01);
    cmp("col_rsp_fixed", rsp_fixed, 16'h0F00);

    // 6b. reset during SETTLE
    tick();
    req_valid = 1'b1; req_inputs = 2'b11;
    @(negedge clk);
    cmp("rst_pre_ready", req_ready, 1);
    @(posedge clk); #1; req_valid = 1'b0; rst = 1'b1;
    tick(); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cmp("rst_no_rsp", rsp_valid, 0);
    end

    // 7. randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = req_valid && req_ready;
      @(posedge clk); #1;
      if (!req_valid || acc) begin
        req_valid  = ($urandom_range(0, 2) != 0);
        req_inputs = 2'($urandom_range(0, 3));
      end
      rsp_ready      = ($urandom_range(0, 3) != 0);
      selftest_start = ($urandom_range(0, 24) == 0);
      rst            = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) begin
        mode_const = 1'($urandom_range(0, 1));
        stub_val   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : stub_pool[$urandom_range(0, 5)];
      end
    end
    req_valid = 1'b0; selftest_start = 1'b0; rst = 1'b0; rsp_ready = 1'b1;
    repeat (20) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
